branch_resolve_ctrl: RTL
========================

// Module: branch_resolve_ctrl
// PURPOSE
//  Sequences the shared 32-bit signed Comparator (inputs A/B; outputs zero/positive/negative)
//  to resolve conditional branches issued by the decode stage.
//  - Accepts one branch at a time. Waits for forwarded operands.
//  - Drives the comparator, evaluates the condition and issues a one-cycle resolve result.
//  - On a taken branch, also issues a PC redirect and a front-end flush.
//  - Sits between decode/hazard logic and fetch.
// PARAMETERS
//  DATA_W   32   operand width; must match the comparator width
//  PC_W     32   program-counter / target width
// PORTS
//  clk              in   1       rising-edge clock
//  rst_n            in   1       asynchronous active-low reset
//  br_valid         in   1       decode presents a branch
//  br_ready         out  1       controller can accept (high only in IDLE)
//  br_cond          in   2       00 BEQ, 01 BNE, 10 BGT (signed), 11 BLT (signed)
//  br_target        in   PC_W    taken-path target address
//  opnd_valid       in   1       forwarded operands are final this cycle
//  opnd_a, opnd_b   in   DATA_W  branch operands (A = rs1, B = rs2)
//  kill             in   1       synchronous squash from a later stage
//  cmp_a, cmp_b     out  DATA_W  registered operands driven to the comparator
//  cmp_zero/pos/neg in   1       comparator flags
//  res_valid        out  1       one-cycle pulse: branch resolved
//  res_taken        out  1       outcome; meaningful only while res_valid is high
//  redirect_valid   out  1       one-cycle pulse; equals res_valid & res_taken
//  redirect_pc      out  PC_W    target for fetch; valid with redirect_valid
//  flush_fe         out  1       flush IF/ID; equals redirect_valid
//  cmp_err          out  1       one-cycle pulse: comparator flags not one-hot
// BEHAVIOUR
//  Reset (rst_n low, asynchronous):
//   - state = IDLE; br_ready = 1.
//   - All other outputs and internal registers = 0; cmp_a = cmp_b = 0.
//  FSM states: IDLE, WAIT_OPND, COMPARE, RESOLVE.
//  IDLE:
//   - br_ready = 1.
//   - br_valid & !kill: capture br_cond and br_target.
//   - If opnd_valid is also high: capture opnd_a/opnd_b into cmp_a/cmp_b and go to COMPARE.
//   - Otherwise go to WAIT_OPND.
//  WAIT_OPND:
//   - Hold the capture. On opnd_valid, load cmp_a/cmp_b and go to COMPARE.
//   - No timeout.
//  COMPARE:
//   - The comparator is combinational on cmp_a/cmp_b; sample the flags this cycle.
//   - taken = BEQ: zero | BNE: !zero | BGT: pos | BLT: neg.
//   - Register taken and go to RESOLVE.
//   - Flags not exactly one-hot: taken = 0 and register an error; cmp_err pulses in RESOLVE.
//  RESOLVE:
//   - res_valid = 1; res_taken = registered taken.
//   - If taken: redirect_valid = flush_fe = 1 and redirect_pc = captured target.
//   - Next state is IDLE; no new accept this cycle.
//  Latency (accept with opnd_valid in cycle T):
//   - COMPARE in T+1; res_valid in T+2; next accept possible in T+3.
//   - Each WAIT_OPND cycle adds one cycle.
//  Kill handling:
//   - kill has priority over every transition.
//   - In any state, kill gives next state IDLE.
//   - In RESOLVE, kill forces res_valid, redirect_valid, flush_fe and cmp_err to 0 that cycle.
//   - kill in IDLE blocks acceptance.
//  Other rules:
//   - Operands are signed two's complement; equality is bitwise.
//   - cmp_a/cmp_b hold their value outside loads.
//   - Pulse outputs are never high for two consecutive cycles.
//   - rst_n low mid-operation aborts immediately; no pulse is emitted.
// TESTING
//  1 BEQ, opnd 5/5 with br_valid -> res_valid at T+2, taken = 1, redirect_pc = br_target, flush_fe = 1.
//  2 BLT, opnd 0xFFFFFFFF/1 -> taken = 1. BGT with the same operands -> taken = 0, no redirect.
//  3 BNE accepted, opnd_valid low 3 cycles, then 7/9 -> res_valid at T+5, taken = 1; br_ready low T+1..T+5.
//  4 kill asserted during RESOLVE of a taken branch -> no res_valid/redirect; IDLE and br_ready = 1 next cycle.
//  5 Force flags 000 or 110 in COMPARE -> cmp_err pulse in RESOLVE, taken = 0.
//  6 rst_n low during WAIT_OPND -> all outputs 0 and br_ready = 1 immediately; no spurious pulse after release.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer: captures a decoded branch, waits for final operands,
// drives the shared signed comparator and issues resolve / redirect / flush pulses.
module branch_resolve_ctrl #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              br_valid,
    output logic              br_ready,
    input  logic [1:0]        br_cond,
    input  logic [PC_W-1:0]   br_target,

    input  logic              opnd_valid,
    input  logic [DATA_W-1:0] opnd_a,
    input  logic [DATA_W-1:0] opnd_b,

    input  logic              kill,

    output logic [DATA_W-1:0] cmp_a,
    output logic [DATA_W-1:0] cmp_b,
    input  logic              cmp_zero,
    input  logic              cmp_pos,
    input  logic              cmp_neg,

    output logic              res_valid,
    output logic              res_taken,
    output logic              redirect_valid,
    output logic [PC_W-1:0]   redirect_pc,
    output logic              flush_fe,
    output logic              cmp_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_OPND = 2'd1,
        COMPARE   = 2'd2,
        RESOLVE   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        BR_BEQ = 2'b00,
        BR_BNE = 2'b01,
        BR_BGT = 2'b10,
        BR_BLT = 2'b11
    } cond_t;

    state_t            state_q, state_d;
    cond_t             cond_q, cond_d;
    logic [PC_W-1:0]   target_q, target_d;
    logic [DATA_W-1:0] cmp_a_q, cmp_a_d;
    logic [DATA_W-1:0] cmp_b_q, cmp_b_d;
    logic              taken_q, taken_d;
    logic              err_q, err_d;

    logic              flags_ok;
    logic              cond_hit;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cond_q   <= BR_BEQ;
            target_q <= '0;
            cmp_a_q  <= '0;
            cmp_b_q  <= '0;
            taken_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cond_q   <= cond_d;
            target_q <= target_d;
            cmp_a_q  <= cmp_a_d;
            cmp_b_q  <= cmp_b_d;
            taken_q  <= taken_d;
            err_q    <= err_d;
        end
    end

    // A healthy comparator asserts exactly one of zero / positive / negative.
    always_comb begin
        flags_ok = 1'b0;
        case ({cmp_zero, cmp_pos, cmp_neg})
            3'b100, 3'b010, 3'b001: flags_ok = 1'b1;
            default:                flags_ok = 1'b0;
        endcase
    end

    always_comb begin
        cond_hit = 1'b0;
        case (cond_q)
            BR_BEQ: cond_hit = cmp_zero;
            BR_BNE: cond_hit = !cmp_zero;
            BR_BGT: cond_hit = cmp_pos;
            BR_BLT: cond_hit = cmp_neg;
            default: cond_hit = 1'b0;
        endcase
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_d        = state_q;
        cond_d         = cond_q;
        target_d       = target_q;
        cmp_a_d        = cmp_a_q;
        cmp_b_d        = cmp_b_q;
        taken_d        = taken_q;
        err_d          = err_q;
        br_ready       = 1'b0;
        res_valid      = 1'b0;
        res_taken      = 1'b0;
        redirect_valid = 1'b0;
        flush_fe       = 1'b0;
        cmp_err        = 1'b0;

        case (state_q)
            IDLE: begin
                br_ready = 1'b1;
                if (br_valid && !kill) begin
                    cond_d   = cond_t'(br_cond);
                    target_d = br_target;
                    if (opnd_valid) begin
                        cmp_a_d = opnd_a;
                        cmp_b_d = opnd_b;
                        state_d = COMPARE;
                    end else begin
                        state_d = WAIT_OPND;
                    end
                end
            end

            WAIT_OPND: begin
                if (kill) begin
                    state_d = IDLE;
                end else if (opnd_valid) begin
                    cmp_a_d = opnd_a;
                    cmp_b_d = opnd_b;
                    state_d = COMPARE;
                end
            end

            COMPARE: begin
                if (kill) begin
                    state_d = IDLE;
                end else begin
                    taken_d = flags_ok && cond_hit;
                    err_d   = !flags_ok;
                    state_d = RESOLVE;
                end
            end

            RESOLVE: begin
                // Always one cycle here; RESOLVE is never an accept slot.
                state_d = IDLE;
                if (!kill) begin
                    res_valid      = 1'b1;
                    res_taken      = taken_q;
                    redirect_valid = taken_q;
                    flush_fe       = taken_q;
                    cmp_err        = err_q;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign cmp_a       = cmp_a_q;
    assign cmp_b       = cmp_b_q;
    assign redirect_pc = redirect_valid ? target_q : '0;

endmodule
